// File: rtl/core_pipe_pkg.sv
// Shared types and encodings for the decode/execute pipeline control slice.
package core_pipe_pkg;

   localparam int unsigned REG_AW = 5;

   // Operand source selects
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   // One in-flight destination record
   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              is_load;
   } pipe_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } hz_state_t;

endpackage

// File: rtl/decode_hazard_ctrl_inflight_tracker.sv
// Match logic of one source operand against the shared EX/MEM/WB in-flight pipe.
module inflight_tracker
   import core_pipe_pkg::*;
(
   input  logic [REG_AW-1:0] rs_addr,
   input  logic              rs_used,
   input  pipe_entry_t       ex_e,
   input  pipe_entry_t       mem_e,
   input  pipe_entry_t       wb_e,
   output logic              ex_load_hit,
   output logic [1:0]        fwd_sel
);

   logic m_ex, m_mem, m_wb;

   // Per-stage match and priority select EX > MEM > WB > regfile
   always_comb begin
      m_ex        = rs_used & ex_e.v  & (ex_e.rd  == rs_addr);
      m_mem       = rs_used & mem_e.v & (mem_e.rd == rs_addr);
      m_wb        = rs_used & wb_e.v  & (wb_e.rd  == rs_addr);
      ex_load_hit = m_ex & ex_e.is_load;
      fwd_sel     = FWD_RF;
      // A load hit in EX falls through here, but that cycle is always a bubble
      if (m_ex && !ex_e.is_load) fwd_sel = FWD_EX;
      else if (m_mem)            fwd_sel = FWD_MEM;
      else if (m_wb)             fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-to-execute hazard controller: load-use stalls, flush bubbles,
// operand forwarding selects, multi-cycle op sequencing and a stall counter.
module decode_hazard_ctrl #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LONG_LAT = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_wr_en,
   input  logic              id_is_load,
   input  logic              id_is_long,
   input  logic              flush,
   output logic              stall_if,
   output logic              de_reg_en,
   output logic              de_bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              ex_busy,
   output logic [CNT_W-1:0]  stall_cnt
);
   import core_pipe_pkg::*;

   pipe_entry_t ex_q, mem_q, wb_q, issue_e;
   hz_state_t   state_q;
   logic [3:0]  busy_ctr_q;
   logic        lu_a, lu_b, load_use, in_idle, issue;
   logic [1:0]  sel_a, sel_b;

   inflight_tracker u_trk_a (
      .rs_addr     (id_rs1_addr),
      .rs_used     (id_rs1_used),
      .ex_e        (ex_q),
      .mem_e       (mem_q),
      .wb_e        (wb_q),
      .ex_load_hit (lu_a),
      .fwd_sel     (sel_a)
   );

   inflight_tracker u_trk_b (
      .rs_addr     (id_rs2_addr),
      .rs_used     (id_rs2_used),
      .ex_e        (ex_q),
      .mem_e       (mem_q),
      .wb_e        (wb_q),
      .ex_load_hit (lu_b),
      .fwd_sel     (sel_b)
   );

   assign in_idle = (state_q == ST_IDLE);
   assign ex_busy = (state_q == ST_BUSY);

   // Hazard decode and the entry that would enter EX this cycle
   always_comb begin
      load_use        = id_valid & (lu_a | lu_b);
      issue           = in_idle & id_valid & ~load_use & ~flush;
      issue_e.v       = issue & id_reg_wr_en & (id_rd != '0);
      issue_e.rd      = id_rd;
      issue_e.is_load = id_is_load;
   end

   // Front-of-pipe controls; reset forces a bubble regardless of id_valid
   always_comb begin
      stall_if  = 1'b0;
      de_reg_en = 1'b1;
      de_bubble = 1'b1;
      if (rst_n) begin
         if (in_idle) begin
            stall_if  = load_use & ~flush;
            de_bubble = flush | load_use | ~id_valid;
         end else begin
            stall_if  = 1'b1;
            de_reg_en = 1'b0;
         end
      end
   end

   // In-flight pipe advances every cycle outside BUSY
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (in_idle) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= issue_e;
      end
   end

   // Multi-cycle op sequencer; flush while BUSY is ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_ctr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue && id_is_long) begin
                  busy_ctr_q <= 4'(LONG_LAT - 1);
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               busy_ctr_q <= busy_ctr_q - 4'd1;
               if (busy_ctr_q == 4'd1) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Forwarding selects aligned with the decode register capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else if (de_reg_en) begin
         fwd_a_sel <= de_bubble ? FWD_RF : sel_a;
         fwd_b_sel <= de_bubble ? FWD_RF : sel_b;
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        stall_cnt <= '0;
      else if (stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr_en, id_is_load, id_is_long, flush;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_rd;

   logic        stall_if, de_reg_en, de_bubble, ex_busy;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] stall_cnt;

   logic        stall_if2, de_reg_en2, de_bubble2, ex_busy2;
   logic [1:0]  fwd_a_sel2, fwd_b_sel2;
   logic [1:0]  stall_cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_hazard_ctrl #(.REG_AW(5), .LONG_LAT(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load),
      .id_is_long(id_is_long), .flush(flush),
      .stall_if(stall_if), .de_reg_en(de_reg_en), .de_bubble(de_bubble),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_busy(ex_busy),
      .stall_cnt(stall_cnt)
   );

   // Narrow counter instance to exercise saturation
   decode_hazard_ctrl #(.REG_AW(5), .LONG_LAT(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load),
      .id_is_long(id_is_long), .flush(flush),
      .stall_if(stall_if2), .de_reg_en(de_reg_en2), .de_bubble(de_bubble2),
      .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .ex_busy(ex_busy2),
      .stall_cnt(stall_cnt2)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       we, ld, lg, fl;
      logic       e_stall, e_en, e_bub, e_busy;
      logic [1:0] e_fa, e_fb;
      int         e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic v, input int rs1, input logic u1,
                               input int rs2, input logic u2, input int rd,
                               input logic we, input logic ld, input logic lg, input logic fl,
                               input logic st, input logic en, input logic bub, input logic busy,
                               input int fa, input int fb, input int cnt);
      vec_t t;
      t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
      t.rd = 5'(rd); t.we = we; t.ld = ld; t.lg = lg; t.fl = fl;
      t.e_stall = st; t.e_en = en; t.e_bub = bub; t.e_busy = busy;
      t.e_fa = 2'(fa); t.e_fb = 2'(fb); t.e_cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v; id_rs1_addr = t.rs1; id_rs1_used = t.u1;
      id_rs2_addr = t.rs2; id_rs2_used = t.u2; id_rd = t.rd;
      id_reg_wr_en = t.we; id_is_load = t.ld; id_is_long = t.lg; flush = t.fl;
   endtask

   // Flush during a busy long op is illegal stimulus
   always @(negedge clk) begin
      if (rst_n && ex_busy && flush) begin
         failures++;
         $display("FAIL flush_in_busy actual=1 required=0");
      end
   end

   initial begin
      vec_t idle;
      idle = mk(0,0,0,0,0,0,0,0,0,0, 0,1,1,0,0,0,0);

      // Forwarding distance EX / MEM / WB / none
      vq.push_back(idle);
      vq.push_back(mk(1, 0,0, 0,0,  5,1,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 5,1, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  6,1,0,0,0, 0,1,0,0, 1,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 6,1, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 0,0, 11,1,0,0,0, 0,1,0,0, 2,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1,11,1, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 0,0, 12,1,0,0,0, 0,1,0,0, 3,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1,12,1,12,1,  0,0,0,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 0,1,1,0, 0,0,0));
      // Load-use stall then MEM forward on operand b
      vq.push_back(mk(1, 0,0, 0,0,  7,1,1,0,0, 0,1,0,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 7,1, 13,1,0,0,0, 1,1,1,0, 0,0,0));
      vq.push_back(mk(1, 0,0, 7,1, 13,1,0,0,0, 0,1,0,0, 0,0,1));
      vq.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 0,1,1,0, 0,2,1));
      // Long op to x9 with a dependent reader behind it
      vq.push_back(mk(1, 0,0, 0,0,  9,1,0,1,0, 0,1,0,0, 0,0,1));
      vq.push_back(mk(1, 9,1, 0,0, 14,1,0,0,0, 1,0,1,1, 0,0,1));
      vq.push_back(mk(1, 9,1, 0,0, 14,1,0,0,0, 1,0,1,1, 0,0,2));
      vq.push_back(mk(1, 9,1, 0,0, 14,1,0,0,0, 1,0,1,1, 0,0,3));
      vq.push_back(mk(1, 9,1, 0,0, 14,1,0,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 0,1,1,0, 1,0,4));
      // Flush beats load-use; killed x15 must never be forwarded
      vq.push_back(mk(1, 0,0, 0,0,  8,1,1,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(1, 8,1, 0,0, 15,1,0,0,1, 0,1,1,0, 0,0,4));
      vq.push_back(mk(1,15,1, 0,0,  0,0,0,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 0,1,1,0, 0,0,4));
      // x0 destination and non-writing instructions are never tracked
      vq.push_back(mk(1, 0,0, 0,0,  0,1,1,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(1, 0,1, 0,1, 16,0,0,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(1, 0,0, 0,0, 17,0,1,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(1,17,1,16,1,  0,0,0,0,0, 0,1,0,0, 0,0,4));
      vq.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 0,1,1,0, 0,0,4));

      // Reset state, with id_valid high to show it is ignored
      drive(mk(1, 0,0, 0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0));
      #2;
      chk("rst stall_if",  32'(stall_if), 32'd0);
      chk("rst de_reg_en", 32'(de_reg_en), 32'd1);
      chk("rst de_bubble", 32'(de_bubble), 32'd1);
      chk("rst ex_busy",   32'(ex_busy), 32'd0);
      chk("rst fwd_a_sel", 32'(fwd_a_sel), 32'd0);
      chk("rst fwd_b_sel", 32'(fwd_b_sel), 32'd0);
      chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
      drive(idle);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1 drive(vq[i]);
         @(negedge clk);
         chk($sformatf("v%0d stall_if", i),  32'(stall_if),  32'(vq[i].e_stall));
         chk($sformatf("v%0d de_reg_en", i), 32'(de_reg_en), 32'(vq[i].e_en));
         if (!vq[i].e_busy)
            chk($sformatf("v%0d de_bubble", i), 32'(de_bubble), 32'(vq[i].e_bub));
         chk($sformatf("v%0d ex_busy", i),   32'(ex_busy),   32'(vq[i].e_busy));
         chk($sformatf("v%0d fwd_a_sel", i), 32'(fwd_a_sel), 32'(vq[i].e_fa));
         chk($sformatf("v%0d fwd_b_sel", i), 32'(fwd_b_sel), 32'(vq[i].e_fb));
         chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vq[i].e_cnt));
         chk($sformatf("v%0d stall_cnt_sat", i), 32'(stall_cnt2),
             32'((vq[i].e_cnt > 3) ? 3 : vq[i].e_cnt));
      end

      // Reset asserted in the middle of a long op
      @(posedge clk);
      #1 drive(mk(1, 0,0, 0,0, 9,1,0,1,0, 0,0,0,0, 0,0,0));
      @(posedge clk);
      #1 drive(mk(1, 9,1, 0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0));
      #1;
      chk("midbusy ex_busy", 32'(ex_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst ex_busy",   32'(ex_busy), 32'd0);
      chk("midrst stall_if",  32'(stall_if), 32'd0);
      chk("midrst de_reg_en", 32'(de_reg_en), 32'd1);
      chk("midrst de_bubble", 32'(de_bubble), 32'd1);
      chk("midrst stall_cnt", 32'(stall_cnt), 32'd0);
      chk("midrst stall_cnt_sat", 32'(stall_cnt2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst ex_busy",   32'(ex_busy), 32'd0);
      chk("postrst fwd_a_sel", 32'(fwd_a_sel), 32'd0);
      chk("postrst stall_if",  32'(stall_if), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
